// File: rtl/crtc_seq_pkg.sv
// crtc_seq_pkg: FSM state type, register count and the video-mode preset
// table shared by crtc_mode_sequencer and crtc_mode_rom.
package crtc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAITVS  = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA    = 3'd3,
    ST_RESTORE = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_t;

  localparam int CRTC_NREGS = 16;

  // R0..R11 per preset; R12..R15 (start address and cursor) always load as 0.
  localparam logic [7:0] CRTC_PRESETS [8][CRTC_NREGS] = '{
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
      8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},  // 40x25 text
    '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
      8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},  // 80x25 text
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70,
      8'h02, 8'h01, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},  // 320/640 graphics
    '{8'h71, 8'h50, 8'h5A, 8'h0E, 8'h3F, 8'h06, 8'h32, 8'h38,
      8'h02, 8'h03, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},  // Tandy 16-colour
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
      8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},  // 4..7 alias 40x25
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
      8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
      8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
      8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00}
  };

  function automatic logic [7:0] preset_byte(input logic [2:0] sel, input logic [3:0] idx);
    return CRTC_PRESETS[sel][idx];
  endfunction

endpackage

// File: rtl/crtc_mode_rom.sv
// crtc_mode_rom: combinational preset byte lookup by mode and register index.
module crtc_mode_rom
  import crtc_seq_pkg::*;
(
  input  logic [2:0] mode_sel,
  input  logic [3:0] idx,
  output logic [7:0] data
);

  // Pure table read; the sequencer holds mode_sel and idx stable per write.
  always_comb begin
    data = preset_byte(mode_sel, idx);
  end

endmodule

// File: rtl/crtc_mode_sequencer.sv
// crtc_mode_sequencer: loads UM6845R registers from a preset table and
// arbitrates the CRTC host port between the CPU and the sequencer.
// Optional feature macro: CRTC_SEQ_VSYNC_ALIGN_EN (start loading on a vsync rise).
//
// state   | meaning
// IDLE    | CPU owns the CRTC bus (pass-through), mode_req sampled
// WAITVS  | waiting for registered vsync rising edge (macro builds only)
// ADDR    | sequencer writes address register with idx
// DATA    | sequencer writes preset byte for idx
// RESTORE | sequencer rewrites the CPU's last-selected address
// DONE    | one-cycle done pulse, bus idle
module crtc_mode_sequencer
  import crtc_seq_pkg::*;
#(
  parameter int NUM_REGS    = CRTC_NREGS,
  parameter bit LOAD_CURSOR = 1'b1
) (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       mode_req,
  input  logic [2:0] mode_sel,
  output logic       busy,
  output logic       done,
  input  logic       vsync,
  input  logic       cpu_cs,
  input  logic       cpu_wr,
  input  logic       cpu_rs,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  output logic       cpu_wait,
  output logic       crtc_en,
  output logic       crtc_ncs,
  output logic       crtc_rnw,
  output logic       crtc_rs,
  output logic [7:0] crtc_di,
  input  logic [7:0] crtc_do
);

  // With cursor loading off, R14/R15 sit at the top of the table, so skipping
  // them is the same as stopping after R13.
  localparam logic [3:0] LAST_IDX = (!LOAD_CURSOR && NUM_REGS > 14) ? 4'd13 : 4'(NUM_REGS - 1);

  seq_state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [2:0] sel_q, sel_d;
  logic [4:0] shadow_addr_q, shadow_addr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] rom_data;
  logic       vs_rise;

`ifdef CRTC_SEQ_VSYNC_ALIGN_EN
  localparam seq_state_t FIRST_STATE = ST_WAITVS;
  logic vsync_q, vs_rise_q;

  // Registered vsync edge detect; the FSM acts on it one cycle after the rise.
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      vsync_q   <= 1'b0;
      vs_rise_q <= 1'b0;
    end else begin
      vsync_q   <= vsync;
      vs_rise_q <= vsync & ~vsync_q;
    end
  end
  assign vs_rise = vs_rise_q;
`else
  localparam seq_state_t FIRST_STATE = ST_ADDR;
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign vs_rise      = 1'b0;
`endif

  crtc_mode_rom u_rom (
    .mode_sel (sel_q),
    .idx      (idx_q),
    .data     (rom_data)
  );

  // Next-state and register-update logic for the sequencer.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sel_d         = sel_q;
    shadow_addr_d = shadow_addr_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_cs && cpu_wr && !cpu_rs) shadow_addr_d = cpu_di[4:0];
        if (mode_req) begin
          sel_d   = mode_sel;
          idx_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = FIRST_STATE;
        end
      end
      ST_WAITVS: begin
        if (vs_rise) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        idx_d   = idx_q + 4'd1;
        state_d = (idx_q == LAST_IDX) ? ST_RESTORE : ST_ADDR;
      end
      ST_RESTORE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      state_q       <= ST_IDLE;
      idx_q         <= 4'd0;
      sel_q         <= 3'd0;
      shadow_addr_q <= 5'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sel_q         <= sel_d;
      shadow_addr_q <= shadow_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // CRTC bus mux: CPU pass-through in IDLE, sequencer writes otherwise.
  always_comb begin
    crtc_en  = 1'b0;
    crtc_ncs = 1'b1;
    crtc_rnw = 1'b1;
    crtc_rs  = 1'b0;
    crtc_di  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        crtc_en  = cpu_cs;
        crtc_ncs = ~cpu_cs;
        crtc_rnw = ~cpu_wr;
        crtc_rs  = cpu_rs;
        crtc_di  = cpu_di;
      end
      ST_ADDR: begin
        crtc_en  = 1'b1;
        crtc_ncs = 1'b0;
        crtc_rnw = 1'b0;
        crtc_di  = {4'b0000, idx_q};
      end
      ST_DATA: begin
        crtc_en  = 1'b1;
        crtc_ncs = 1'b0;
        crtc_rnw = 1'b0;
        crtc_rs  = 1'b1;
        crtc_di  = rom_data;
      end
      ST_RESTORE: begin
        crtc_en  = 1'b1;
        crtc_ncs = 1'b0;
        crtc_rnw = 1'b0;
        crtc_di  = {3'b000, shadow_addr_q};
      end
      default: begin
        crtc_en  = 1'b0;
      end
    endcase
  end

  // CPU sees real read data only while it owns the bus.
  always_comb begin
    cpu_do   = (state_q == ST_IDLE && cpu_cs) ? crtc_do : 8'hFF;
    cpu_wait = busy_q & cpu_cs;
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_crtc_mode_sequencer.sv
module tb_crtc_mode_sequencer;

  logic       CLOCK = 1'b0;
  logic       nRESET = 1'b0;
  logic       mode_req = 1'b0, mode_req_nc = 1'b0;
  logic [2:0] mode_sel = 3'd0;
  logic       vsync = 1'b0;
  logic       cpu_cs = 1'b0, cpu_wr = 1'b0, cpu_rs = 1'b0;
  logic [7:0] cpu_di = 8'h00;

  logic       busy, done, cpu_wait, crtc_en, crtc_ncs, crtc_rnw, crtc_rs;
  logic [7:0] cpu_do, crtc_di, crtc_do;
  logic       busy_nc, done_nc, cpu_wait_nc, crtc_en_nc, crtc_ncs_nc, crtc_rnw_nc, crtc_rs_nc;
  logic [7:0] cpu_do_nc, crtc_di_nc, crtc_do_nc;

  int errors = 0;
  int checks = 0;

`ifdef CRTC_SEQ_VSYNC_ALIGN_EN
  localparam int VSX = 102;
  localparam int VSX_NC = 6;
`else
  localparam int VSX = 0;
  localparam int VSX_NC = 0;
`endif

  always #5 CLOCK = ~CLOCK;

  crtc_mode_sequencer u_dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .mode_req(mode_req), .mode_sel(mode_sel),
    .busy(busy), .done(done), .vsync(vsync),
    .cpu_cs(cpu_cs), .cpu_wr(cpu_wr), .cpu_rs(cpu_rs), .cpu_di(cpu_di),
    .cpu_do(cpu_do), .cpu_wait(cpu_wait),
    .crtc_en(crtc_en), .crtc_ncs(crtc_ncs), .crtc_rnw(crtc_rnw), .crtc_rs(crtc_rs),
    .crtc_di(crtc_di), .crtc_do(crtc_do)
  );

  crtc_mode_sequencer #(.NUM_REGS(16), .LOAD_CURSOR(1'b0)) u_dut_nc (
    .CLOCK(CLOCK), .nRESET(nRESET), .mode_req(mode_req_nc), .mode_sel(mode_sel),
    .busy(busy_nc), .done(done_nc), .vsync(vsync),
    .cpu_cs(cpu_cs), .cpu_wr(cpu_wr), .cpu_rs(cpu_rs), .cpu_di(cpu_di),
    .cpu_do(cpu_do_nc), .cpu_wait(cpu_wait_nc),
    .crtc_en(crtc_en_nc), .crtc_ncs(crtc_ncs_nc), .crtc_rnw(crtc_rnw_nc), .crtc_rs(crtc_rs_nc),
    .crtc_di(crtc_di_nc), .crtc_do(crtc_do_nc)
  );

  // Behavioural CRTC register files behind each DUT.
  logic [7:0] regs_m [32];
  logic [4:0] addr_m;
  logic [7:0] regs_nc [32];
  logic [4:0] addr_nc;

  always @(posedge CLOCK) begin
    if (!nRESET) begin
      addr_m <= 5'd0;
      for (int k = 0; k < 32; k++) regs_m[k] <= 8'h00;
    end else if (crtc_en && !crtc_rnw) begin
      if (!crtc_rs) addr_m <= crtc_di[4:0];
      else regs_m[addr_m] <= crtc_di;
    end
  end
  assign crtc_do = regs_m[addr_m];

  always @(posedge CLOCK) begin
    if (!nRESET) begin
      addr_nc <= 5'd0;
      for (int k = 0; k < 32; k++) regs_nc[k] <= 8'h00;
    end else if (crtc_en_nc && !crtc_rnw_nc) begin
      if (!crtc_rs_nc) addr_nc <= crtc_di_nc[4:0];
      else regs_nc[addr_nc] <= crtc_di_nc;
    end
  end
  assign crtc_do_nc = regs_nc[addr_nc];

  typedef struct {
    logic [2:0] sel;
    int         rid;
    logic [4:0] addr;
    logic       hold;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_row [4][16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_wait"}, cpu_wait, 1'b0);
    chk({tag, "_cpu_do"}, cpu_do, 8'hFF);
    chk({tag, "_bus"}, {crtc_en, crtc_ncs, crtc_rnw, crtc_rs}, 4'b0110);
    chk({tag, "_di"}, crtc_di, 8'h00);
  endtask

  task automatic cpu_write(input logic rs, input logic [7:0] d);
    cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_rs = rs; cpu_di = d;
    #1;
    chk("pass_bus", {crtc_en, crtc_ncs, crtc_rnw, crtc_rs}, {3'b100, rs});
    chk("pass_di", crtc_di, d);
    step();
    cpu_cs = 1'b0; cpu_wr = 1'b0; cpu_rs = 1'b0; cpu_di = 8'h00;
  endtask

  // Full request on the main DUT, checked cycle by cycle from acceptance.
  task automatic run_seq(input logic [2:0] sel, input int rid, input logic [4:0] shadow, input logic hold);
    int cyc;
    int bad;
    mode_sel = sel; mode_req = 1'b1;
    #1;
    chk("accept_busy", busy, 1'b0);
    step();
    mode_req = 1'b0; cyc = 1; bad = 0;
    if (hold) begin cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_rs = 1'b0; cpu_di = 8'h15; end
`ifdef CRTC_SEQ_VSYNC_ALIGN_EN
    for (int j = 0; j < 100; j++) begin
      #1;
      if (crtc_en !== 1'b0 || busy !== 1'b1) bad++;
      step(); cyc++;
    end
    vsync = 1'b1;
    #1;
    if (crtc_en !== 1'b0) bad++;
    step(); cyc++;
    #1;
    if (crtc_en !== 1'b0 || busy !== 1'b1) bad++;
    step(); cyc++;
    vsync = 1'b0;
    chk("waitvs_idle_bus", bad, 0);
`endif
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("addr_bus", {crtc_en, crtc_ncs, crtc_rnw, crtc_rs}, 4'b1000);
      chk("addr_di", crtc_di, i);
      chk("seq_busy", busy, 1'b1);
      if (hold) begin
        chk("cpu_wait", cpu_wait, 1'b1);
        chk("cpu_do_blocked", cpu_do, 8'hFF);
      end
      step(); cyc++;
      #1;
      chk("data_bus", {crtc_en, crtc_ncs, crtc_rnw, crtc_rs}, 4'b1001);
      chk("data_di", crtc_di, exp_row[rid][i]);
      step(); cyc++;
    end
    #1;
    chk("restore_bus", {crtc_en, crtc_ncs, crtc_rnw, crtc_rs}, 4'b1000);
    chk("restore_di", crtc_di, {3'b000, shadow});
    chk("restore_done", done, 1'b0);
    chk("restore_busy", busy, 1'b1);
    step(); cyc++;
    #1;
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_cycle", cyc, 34 + VSX);
    chk("done_bus_idle", {crtc_en, crtc_ncs, crtc_rnw}, 3'b011);
    chk("done_wait", cpu_wait, 1'b0);
    cpu_cs = 1'b0; cpu_wr = 1'b0; cpu_rs = 1'b0; cpu_di = 8'h00;
    step();
    #1;
    chk("done_clear", done, 1'b0);
    chk("crtc_addr_restored", addr_m, shadow);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cyc, done_at, na, nd;

    exp_row[0] = '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
                   8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_row[1] = '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
                   8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_row[2] = '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70,
                   8'h02, 8'h01, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_row[3] = '{8'h71, 8'h50, 8'h5A, 8'h0E, 8'h3F, 8'h06, 8'h32, 8'h38,
                   8'h02, 8'h03, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[0] = '{3'd1, 1, 5'h00, 1'b0};
    vecs[1] = '{3'd0, 0, 5'h0E, 1'b0};
    vecs[2] = '{3'd2, 2, 5'h03, 1'b1};
    vecs[3] = '{3'd3, 3, 5'h1F, 1'b0};
    vecs[4] = '{3'd6, 0, 5'h0C, 1'b0};
    vecs[5] = '{3'd4, 0, 5'h07, 1'b1};

    // Reset state.
    nRESET = 1'b0;
    step(); step();
    #1;
    chk_reset_vals("reset");
    nRESET = 1'b1;
    step();

    // Table-driven mode loads.
    for (int v = 0; v < 6; v++) begin
      cpu_write(1'b0, {3'b000, vecs[v].addr});
      run_seq(vecs[v].sel, vecs[v].rid, vecs[v].addr, vecs[v].hold);
      cpu_cs = 1'b1; cpu_wr = 1'b0; cpu_rs = 1'b1;
      #1;
      chk("cpu_read_bus", {crtc_en, crtc_ncs, crtc_rnw, crtc_rs}, 4'b1011);
      chk("cpu_readback", cpu_do, (vecs[v].addr < 16) ? exp_row[vecs[v].rid][vecs[v].addr[3:0]] : 8'h00);
      step();
      cpu_cs = 1'b0; cpu_wr = 1'b0; cpu_rs = 1'b0;
    end

    // Cursor registers left alone when LOAD_CURSOR=0.
    cpu_write(1'b0, 8'd14);
    cpu_write(1'b1, 8'h12);
    chk("nc_preload_r14", regs_nc[14], 8'h12);
    mode_sel = 3'd2; mode_req_nc = 1'b1;
    step();
    mode_req_nc = 1'b0;
    cyc = 1; done_at = 0; na = 0; nd = 0;
    while (done_at == 0 && cyc < 200) begin
`ifdef CRTC_SEQ_VSYNC_ALIGN_EN
      vsync = (cyc >= 5 && cyc < 7);
`endif
      #1;
      if (done_nc) done_at = cyc;
      else begin
        if (crtc_en_nc && !crtc_rnw_nc) begin
          if (crtc_rs_nc) nd++;
          else na++;
        end
        step(); cyc++;
      end
    end
    vsync = 1'b0;
    chk("nc_done_cycle", done_at, 30 + VSX_NC);
    chk("nc_addr_writes", na, 15);
    chk("nc_data_writes", nd, 14);
    chk("nc_r9_loaded", regs_nc[9], 8'h01);
    chk("nc_r15_untouched", regs_nc[15], 8'h00);
    step();
    cpu_cs = 1'b1; cpu_wr = 1'b0; cpu_rs = 1'b1;
    #1;
    chk("nc_r14_readback", cpu_do_nc, 8'h12);
    step();
    cpu_cs = 1'b0; cpu_rs = 1'b0;

    // Reset in the middle of a sequence, then a clean request.
    mode_sel = 3'd3; mode_req = 1'b1;
    step();
    mode_req = 1'b0;
    for (int j = 1; j < 10; j++) step();
    nRESET = 1'b0;
    step();
    #1;
    chk_reset_vals("midreset");
    nRESET = 1'b1;
    step();
    #1;
    chk("post_reset_idle", {busy, crtc_en}, 2'b00);
    run_seq(3'd1, 1, 5'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
